// File: rtl/instruction_encoder_if.sv
// Handshake and field bundle between an instruction producer and instruction_encoder.
// The producer uses master and the encoder uses slave.
interface instruction_encoder_if #(
    parameter int ADDR_WIDTH = 10
);
    logic                  in_valid;
    logic                  in_ready;
    logic [6:0]            in_opcode;
    logic [4:0]            in_rd;
    logic [4:0]            in_rs1;
    logic [4:0]            in_rs2;
    logic [2:0]            in_funct3;
    logic [6:0]            in_funct7;
    logic [63:0]           in_imm;
    logic                  out_valid;
    logic                  out_ready;
    logic [31:0]           out_instr;
    logic [ADDR_WIDTH-1:0] out_addr;
    logic                  err_imm;
    logic                  err_opcode;
    logic                  clear_err;

    modport master (
        output in_valid, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm,
        output out_ready, clear_err,
        input  in_ready, out_valid, out_instr, out_addr, err_imm, err_opcode
    );

    modport slave (
        input  in_valid, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm,
        input  out_ready, clear_err,
        output in_ready, out_valid, out_instr, out_addr, err_imm, err_opcode
    );
endinterface

// File: rtl/instruction_encoder.sv
// Packs RV64I fields plus a signed immediate into a 32-bit word tagged with a sequential word address.
// Latency 2 cycles (stage 1 classify/range-check, stage 2 pack/hold), 1 word per cycle.
// Backpressure: stage 2 holds its word while out_ready is low; in_ready drops once both stages are full.
// Optional IMM_RANGE_CHECK_EN: out-of-range immediates are dropped and flagged on err_imm.
module instruction_encoder #(
    parameter int                    ADDR_WIDTH = 10,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input logic                  clk,
    input logic                  rst_n,
    instruction_encoder_if.slave bus
);
    typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_BAD} fmt_e;

    fmt_e                  in_fmt;
    fmt_e                  s1_fmt;
    logic                  imm_ok;
    logic                  in_fire;
    logic                  in_keep;
    logic                  s2_adv;
    logic                  s1_valid;
    logic                  s2_valid;
    logic [6:0]            s1_opcode;
    logic [6:0]            s1_funct7;
    logic [4:0]            s1_rd;
    logic [4:0]            s1_rs1;
    logic [4:0]            s1_rs2;
    logic [2:0]            s1_funct3;
    logic [31:0]           s1_imm;
    logic [31:0]           packed_word;
    logic [31:0]           out_instr_q;
    logic [ADDR_WIDTH-1:0] out_addr_q;
    logic [ADDR_WIDTH-1:0] addr_cnt;
    logic                  err_opcode_q;

    always_comb begin
        in_fmt = FMT_BAD;
        case (bus.in_opcode)
            7'b0110011:                         in_fmt = FMT_R;
            7'b0010011, 7'b0000011, 7'b1100111: in_fmt = FMT_I;
            7'b0100011:                         in_fmt = FMT_S;
            7'b1100011:                         in_fmt = FMT_B;
            7'b0110111, 7'b0010111:             in_fmt = FMT_U;
            7'b1101111:                         in_fmt = FMT_J;
            default:                            in_fmt = FMT_BAD;
        endcase
    end

`ifdef IMM_RANGE_CHECK_EN
    // An immediate fits when every bit above the field's sign bit copies it.
    logic sext11;
    logic sext12;
    logic sext20;
    logic sext31;
    logic err_imm_q;

    assign sext11 = (&bus.in_imm[63:11]) || !(|bus.in_imm[63:11]);
    assign sext12 = (&bus.in_imm[63:12]) || !(|bus.in_imm[63:12]);
    assign sext20 = (&bus.in_imm[63:20]) || !(|bus.in_imm[63:20]);
    assign sext31 = (&bus.in_imm[63:31]) || !(|bus.in_imm[63:31]);

    always_comb begin
        imm_ok = 1'b1;
        case (in_fmt)
            FMT_I, FMT_S: imm_ok = sext11;
            FMT_B:        imm_ok = sext12 && !bus.in_imm[0];
            FMT_J:        imm_ok = sext20 && !bus.in_imm[0];
            FMT_U:        imm_ok = sext31 && !(|bus.in_imm[11:0]);
            default:      imm_ok = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_imm_q <= 1'b0;
        end else if (in_fire && (in_fmt != FMT_BAD) && !imm_ok) begin
            err_imm_q <= 1'b1;
        end else if (bus.clear_err) begin
            err_imm_q <= 1'b0;
        end
    end

    assign bus.err_imm = err_imm_q;
`else
    assign imm_ok      = 1'b1;
    assign bus.err_imm = 1'b0;
`endif

    assign s2_adv       = !s2_valid || bus.out_ready;
    assign bus.in_ready = !s1_valid || s2_adv;
    assign in_fire      = bus.in_valid && bus.in_ready;
    assign in_keep      = (in_fmt != FMT_BAD) && imm_ok;

    // Rejected words never occupy stage 1, so they cannot consume an address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_fmt    <= FMT_R;
            s1_opcode <= '0;
            s1_funct7 <= '0;
            s1_rd     <= '0;
            s1_rs1    <= '0;
            s1_rs2    <= '0;
            s1_funct3 <= '0;
            s1_imm    <= '0;
        end else if (in_fire) begin
            s1_valid  <= in_keep;
            s1_fmt    <= in_fmt;
            s1_opcode <= bus.in_opcode;
            s1_funct7 <= bus.in_funct7;
            s1_rd     <= bus.in_rd;
            s1_rs1    <= bus.in_rs1;
            s1_rs2    <= bus.in_rs2;
            s1_funct3 <= bus.in_funct3;
            s1_imm    <= bus.in_imm[31:0];
        end else if (s2_adv) begin
            s1_valid  <= 1'b0;
        end
    end

    always_comb begin
        packed_word = '0;
        case (s1_fmt)
            FMT_R: packed_word = {s1_funct7, s1_rs2, s1_rs1, s1_funct3, s1_rd, s1_opcode};
            FMT_I: packed_word = {s1_imm[11:0], s1_rs1, s1_funct3, s1_rd, s1_opcode};
            FMT_S: packed_word = {s1_imm[11:5], s1_rs2, s1_rs1, s1_funct3, s1_imm[4:0], s1_opcode};
            FMT_B: packed_word = {s1_imm[12], s1_imm[10:5], s1_rs2, s1_rs1, s1_funct3,
                                  s1_imm[4:1], s1_imm[11], s1_opcode};
            FMT_U: packed_word = {s1_imm[31:12], s1_rd, s1_opcode};
            FMT_J: packed_word = {s1_imm[20], s1_imm[10:1], s1_imm[11], s1_imm[19:12],
                                  s1_rd, s1_opcode};
            default: packed_word = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid    <= 1'b0;
            out_instr_q <= '0;
            out_addr_q  <= BASE_ADDR;
            addr_cnt    <= BASE_ADDR;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                out_instr_q <= packed_word;
                out_addr_q  <= addr_cnt;
                addr_cnt    <= addr_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_opcode_q <= 1'b0;
        end else if (in_fire && (in_fmt == FMT_BAD)) begin
            err_opcode_q <= 1'b1;
        end else if (bus.clear_err) begin
            err_opcode_q <= 1'b0;
        end
    end

    assign bus.out_valid  = s2_valid;
    assign bus.out_instr  = out_instr_q;
    assign bus.out_addr   = out_addr_q;
    assign bus.err_opcode = err_opcode_q;
endmodule
